// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration-counter sizing and the fill value used for a divide-by-zero quotient.
package div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Default operand width and the matching iteration-counter width
  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_ITER_W        = $clog2(DIV_WIDTH_DEFAULT + 1);

  // Every quotient bit is forced to this value when the divisor is zero
  localparam logic DIV0_QUOT_BIT = 1'b1;

  // Iteration-counter width for an arbitrary operand width
  function automatic int div_iter_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift the partial remainder left,
// bring in the next dividend bit, trial-subtract the divisor magnitude and
// keep the difference only when it does not go negative.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] divisor_ext_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; the shifted remainder is one bit wider than the divisor
  always_comb begin
    shifted_s     = {rem, dividend_bit};
    divisor_ext_s = {1'b0, divisor_mag};
    diff_s        = shifted_s - divisor_ext_s;
    if (shifted_s >= divisor_ext_s) begin
      // Difference is below the divisor, so it fits back into WIDTH bits
      next_rem = diff_s[WIDTH-1:0];
      quot_bit = 1'b1;
    end else begin
      // Shifted value is below the divisor, so its top bit is zero
      next_rem = shifted_s[WIDTH-1:0];
      quot_bit = 1'b0;
    end
  end

endmodule

// File: rtl/axis_seq_divider.sv
// Sequential radix-2 restoring divider with a dividend/divisor/dout stream
// interface. One operand pair is accepted in IDLE, WIDTH restoring steps run in
// CALC, and the sign-corrected {quotient, remainder} is presented with a
// single-cycle valid strobe in DONE. Latency is fixed at WIDTH+1 cycles.
module axis_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH_DEFAULT,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               s_axis_dividend_tready,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               s_axis_divisor_tready,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int                ITER_W    = div_iter_width(WIDTH);
  localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  DIV0_QUOT = {WIDTH{DIV0_QUOT_BIT}};

  // FSM
  div_state_e state_r;
  div_state_e state_nxt_s;
  logic       accept_s;
  logic       step_s;
  logic       finish_s;

  // Operand decode
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;

  // Iteration datapath
  logic [ITER_W-1:0] iter_cnt_r;
  logic [WIDTH-1:0]  dvd_shift_r;
  logic [WIDTH-1:0]  dvs_mag_r;
  logic [WIDTH-1:0]  dvd_raw_r;
  logic [WIDTH-1:0]  rem_r;
  logic [WIDTH-1:0]  quot_r;
  logic              neg_quot_r;
  logic              neg_rem_r;
  logic              div_zero_r;
  logic [WIDTH-1:0]  step_rem_s;
  logic              step_qbit_s;

  // Result formation
  logic [WIDTH-1:0]   quot_mag_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [2*WIDTH-1:0] result_s;

  // Output registers
  logic               tready_r;
  logic               dout_tvalid_r;
  logic [2*WIDTH-1:0] dout_tdata_r;

  // Restoring step on the current partial remainder and next dividend MSB
  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem          (rem_r),
    .dividend_bit (dvd_shift_r[WIDTH-1]),
    .divisor_mag  (dvs_mag_r),
    .next_rem     (step_rem_s),
    .quot_bit     (step_qbit_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a pair is taken only when both valids are high in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (iter_cnt_r == LAST_ITER) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
      end
      ST_CALC: begin
        step_s   = 1'b1;
        finish_s = (iter_cnt_r == LAST_ITER);
      end
      ST_DONE: begin
        accept_s = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Sign extraction and magnitude conversion of the incoming operands
  always_comb begin
    if (SIGNED) begin
      dvd_neg_s = s_axis_dividend_tdata[WIDTH-1];
      dvs_neg_s = s_axis_divisor_tdata[WIDTH-1];
    end else begin
      dvd_neg_s = 1'b0;
      dvs_neg_s = 1'b0;
    end
    // The most-negative value maps to 2^(WIDTH-1), which is representable unsigned
    if (dvd_neg_s) begin
      dvd_mag_s = ZERO_W - s_axis_dividend_tdata;
    end else begin
      dvd_mag_s = s_axis_dividend_tdata;
    end
    if (dvs_neg_s) begin
      dvs_mag_s = ZERO_W - s_axis_divisor_tdata;
    end else begin
      dvs_mag_s = s_axis_divisor_tdata;
    end
  end

  // Operand latch on accept, then one shift/subtract per CALC cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_cnt_r  <= ITER_ZERO;
      dvd_shift_r <= ZERO_W;
      dvs_mag_r   <= ZERO_W;
      dvd_raw_r   <= ZERO_W;
      rem_r       <= ZERO_W;
      quot_r      <= ZERO_W;
      neg_quot_r  <= 1'b0;
      neg_rem_r   <= 1'b0;
      div_zero_r  <= 1'b0;
    end else if (accept_s) begin
      iter_cnt_r  <= ITER_ZERO;
      dvd_shift_r <= dvd_mag_s;
      dvs_mag_r   <= dvs_mag_s;
      dvd_raw_r   <= s_axis_dividend_tdata;
      rem_r       <= ZERO_W;
      quot_r      <= ZERO_W;
      neg_quot_r  <= dvd_neg_s ^ dvs_neg_s;
      neg_rem_r   <= dvd_neg_s;
      div_zero_r  <= (s_axis_divisor_tdata == ZERO_W);
    end else if (step_s) begin
      iter_cnt_r  <= finish_s ? ITER_ZERO : (iter_cnt_r + ITER_ONE);
      dvd_shift_r <= {dvd_shift_r[WIDTH-2:0], 1'b0};
      rem_r       <= step_rem_s;
      quot_r      <= {quot_r[WIDTH-2:0], step_qbit_s};
    end
  end

  // Final quotient/remainder including the last step, with sign fix-up.
  // Divide-by-zero overrides the datapath so both modes return {ones, dividend}.
  always_comb begin
    quot_mag_s = {quot_r[WIDTH-2:0], step_qbit_s};
    if (div_zero_r) begin
      quot_fix_s = DIV0_QUOT;
      rem_fix_s  = dvd_raw_r;
    end else begin
      if (neg_quot_r) begin
        quot_fix_s = ZERO_W - quot_mag_s;
      end else begin
        quot_fix_s = quot_mag_s;
      end
      if (neg_rem_r) begin
        rem_fix_s = ZERO_W - step_rem_s;
      end else begin
        rem_fix_s = step_rem_s;
      end
    end
    result_s = {quot_fix_s, rem_fix_s};
  end

  // Registered outputs: result and strobe are loaded on the edge entering DONE,
  // ready follows the state about to be entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tready_r      <= 1'b1;
      dout_tvalid_r <= 1'b0;
      dout_tdata_r  <= {(2*WIDTH){1'b0}};
    end else begin
      tready_r      <= (state_nxt_s == ST_IDLE);
      dout_tvalid_r <= finish_s;
      if (finish_s) begin
        dout_tdata_r <= result_s;
      end
    end
  end

  assign s_axis_dividend_tready = tready_r;
  assign s_axis_divisor_tready  = tready_r;
  assign m_axis_dout_tvalid     = dout_tvalid_r;
  assign m_axis_dout_tdata      = dout_tdata_r;

endmodule

// File: tb/tb_axis_seq_divider.sv
// Self-checking bench for axis_seq_divider: a signed and an unsigned instance
// share one stimulus stream; a cycle-level behavioural model predicts strobe,
// ready and held result, and directed cases pin literal results.
module tb_axis_seq_divider;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           dvd_valid;
  logic           dvs_valid;
  logic [W-1:0]   dvd_data;
  logic [W-1:0]   dvs_data;

  logic           dvd_rdy_s, dvs_rdy_s, vld_s;
  logic [2*W-1:0] dat_s;
  logic           dvd_rdy_u, dvs_rdy_u, vld_u;
  logic [2*W-1:0] dat_u;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tready (dvd_rdy_s),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tready  (dvs_rdy_s),
    .m_axis_dout_tvalid     (vld_s),
    .m_axis_dout_tdata      (dat_s)
  );

  axis_seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tready (dvd_rdy_u),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tready  (dvs_rdy_u),
    .m_axis_dout_tvalid     (vld_u),
    .m_axis_dout_tdata      (dat_u)
  );

  // Reference division using plain 64-bit arithmetic (truncating, remainder
  // follows dividend sign); divide-by-zero gives {all ones, dividend}
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[W-1:0], r[W-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             m_idle  = 1'b1;
  int             m_cnt   = 0;
  bit             m_valid = 1'b0;
  logic [2*W-1:0] m_res_s = '0;
  logic [2*W-1:0] m_res_u = '0;
  logic [2*W-1:0] m_pend_s, m_pend_u;
  bit             chk_en  = 1'b0;

  // Accept when idle with both valids; result shows W edges later for one cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_cnt = 0; m_valid = 1'b0; m_res_s = '0; m_res_u = '0;
    end else if (m_valid) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end else if (!m_idle) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_res_s = m_pend_s;
        m_res_u = m_pend_u;
      end
    end else if (dvd_valid && dvs_valid) begin
      m_idle   = 1'b0;
      m_cnt    = W;
      m_pend_s = ref_div(dvd_data, dvs_data, 1'b1);
      m_pend_u = ref_div(dvd_data, dvs_data, 1'b0);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tvalid_signed",   64'(vld_s), 64'(m_valid));
      chk("tvalid_unsigned", 64'(vld_u), 64'(m_valid));
      chk("tready_signed",   64'({dvd_rdy_s, dvs_rdy_s}), 64'({m_idle, m_idle}));
      chk("tready_unsigned", 64'({dvd_rdy_u, dvs_rdy_u}), 64'({m_idle, m_idle}));
      chk("tdata_signed",    dat_s, m_res_s);
      chk("tdata_unsigned",  dat_u, m_res_u);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_strobe(input int bound, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 1; k <= bound && !got; k++) begin
      @(negedge clk);
      if (vld_s) begin
        got = 1'b1;
        lat = k;
      end
    end
  endtask

  task automatic do_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_s, input logic [2*W-1:0] exp_u,
                         input string nm);
    int lat;
    @(posedge clk); #1;
    dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    wait_strobe(W + 8, lat);
    chk({nm, "_latency"}, 64'(lat), 64'(W + 1));
    chk({nm, "_signed"}, dat_s, exp_s);
    chk({nm, "_unsigned_vld"}, 64'(vld_u), 64'd1);
    chk({nm, "_unsigned"}, dat_u, exp_u);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return W'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, pulses, gap, hold, kind;
    logic [W-1:0] a, b;

    rst_n = 1'b0; dvd_valid = 1'b0; dvs_valid = 1'b0; dvd_data = '0; dvs_data = '0;

    // Hand-computed values pinning the reference model itself
    chk("model_100_7",     ref_div(32'd100, 32'd7, 1'b1),                   64'h0000000E_00000002);
    chk("model_m7_2",      ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),             64'hFFFFFFFD_FFFFFFFF);
    chk("model_ovf",       ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),     64'h80000000_00000000);
    chk("model_uns_max_2", ref_div(32'hFFFF_FFFF, 32'd2, 1'b0),             64'h7FFFFFFF_00000001);
    chk("model_div0",      ref_div(32'h1234_5678, 32'd0, 1'b1),             64'hFFFFFFFF_12345678);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_tvalid", 64'({vld_s, vld_u}), 64'd0);
    chk("reset_tdata",  dat_s | dat_u, 64'd0);
    chk("reset_tready", 64'({dvd_rdy_s, dvs_rdy_s, dvd_rdy_u, dvs_rdy_u}), 64'hF);

    // Directed literal cases
    do_pair(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, "t100_7");
    do_pair(32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001, "tm7_2");
    do_pair(32'd7, 32'hFFFF_FFFE, 64'hFFFFFFFD_00000001, 64'h00000000_00000007, "t7_m2");
    do_pair(32'h1234_5678, 32'd0, 64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678, "tdiv0");
    do_pair(32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 64'h00000000_80000000, "tovf");
    do_pair(32'hFFFF_FFFF, 32'd2, 64'h00000000_FFFFFFFF, 64'h7FFFFFFF_00000001, "tmax_2");

    // Valids held through CALC with changing data: only the latched pair counts
    @(posedge clk); #1;
    dvd_data = 32'd1000; dvs_data = 32'd10; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk); #1;
    dvd_data = $urandom; dvs_data = $urandom;
    lat = 0;
    for (int k = 1; k <= W + 8 && lat == 0; k++) begin
      @(negedge clk);
      if (vld_s) lat = k;
      else begin
        @(posedge clk); #1;
        dvd_data = $urandom; dvs_data = $urandom;
      end
    end
    chk("hold_latency", 64'(lat), 64'(W + 1));
    chk("hold_signed", dat_s, 64'h00000064_00000000);
    chk("hold_unsigned", dat_u, 64'h00000064_00000000);
    @(posedge clk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (vld_s || vld_u) pulses++;
    end
    chk("hold_no_duplicate", 64'(pulses), 64'd0);
    do_pair(32'd7, 32'd3, 64'h00000002_00000001, 64'h00000002_00000001, "hold_second");

    // Reset pulse mid-CALC aborts the operation
    @(posedge clk); #1;
    dvd_data = 32'd100; dvs_data = 32'd7; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (vld_s || vld_u) pulses++;
    end
    chk("abort_no_strobe", 64'(pulses), 64'd0);
    chk("abort_tdata", dat_s | dat_u, 64'd0);
    do_pair(32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000, "after_abort");

    // Randomized traffic checked by the model
    for (int t = 0; t < 60; t++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        kind = $urandom_range(0, 2);
        dvd_data = $urandom; dvs_data = $urandom;
        dvd_valid = (kind == 1); dvs_valid = (kind == 2);
      end
      a = pick_val(); b = pick_val();
      hold = $urandom_range(0, 1);
      @(posedge clk); #1;
      dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin
        dvd_valid = 1'b0; dvs_valid = 1'b0;
      end
      if (!hold && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        lat = 0;
        for (int k = 1; k <= W + 8 && lat == 0; k++) begin
          @(negedge clk);
          if (vld_s) lat = k;
          else if (hold) begin
            @(posedge clk); #1;
            dvd_data = $urandom; dvs_data = $urandom;
          end
        end
        chk("rand_latency", 64'(lat), 64'(W + 1));
        if (hold) begin
          @(posedge clk); #1;
          dvd_valid = 1'b0; dvs_valid = 1'b0;
        end
      end
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
